// File: rtl/exp_job_sequencer.sv
// Job sequencer around the exponential evaluator: queues Q0.16 arguments,
// runs them one at a time and returns each Q2.16 result tagged with its argument.
module exp_job_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [15:0]            in_x,
  output logic                   in_ready,
  output logic                   exp_start,
  output logic [15:0]            exp_x,
  input  logic                   exp_done,
  input  logic [1:0]             exp_int,
  input  logic [15:0]            exp_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_x,
  output logic [17:0]            out_result,
  output logic                   out_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_n;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_done_q, w_done_q_n;
  logic            r_start, w_start_n;
  logic [15:0]     r_x, w_x_n;
  logic            r_valid, w_valid_n;
  logic [15:0]     r_ox, w_ox_n;
  logic [17:0]     r_res, w_res_n;
  logic            r_to, w_to_n;
  logic            r_busy, w_busy_n;
  logic            w_push, w_pop;

  assign in_ready    = (r_count != FULL);
  assign w_push      = in_valid && in_ready;
  assign q_count     = r_count;
  assign exp_start   = r_start;
  assign exp_x       = r_x;
  assign out_valid   = r_valid;
  assign out_x       = r_ox;
  assign out_result  = r_res;
  assign out_timeout = r_to;
  assign busy        = r_busy;

  // Argument storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_x;
  end

  // Circular FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done_q <= 1'b0;
      r_start  <= 1'b0;
      r_x      <= '0;
      r_valid  <= 1'b0;
      r_ox     <= '0;
      r_res    <= '0;
      r_to     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_done_q <= w_done_q_n;
      r_start  <= w_start_n;
      r_x      <= w_x_n;
      r_valid  <= w_valid_n;
      r_ox     <= w_ox_n;
      r_res    <= w_res_n;
      r_to     <= w_to_n;
      r_busy   <= w_busy_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_done_q_n = exp_done;
    w_start_n  = r_start;
    w_x_n      = r_x;
    w_valid_n  = r_valid;
    w_ox_n     = r_ox;
    w_res_n    = r_res;
    w_to_n     = r_to;
    w_pop      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop      = 1'b1;
          w_x_n      = r_mem[r_rptr];
          w_cnt_n    = '0;
          w_start_n  = 1'b1;
          w_done_q_n = 1'b0;
          w_state_n  = S_START;
        end
      end
      S_START: begin
        if (r_cnt == CW'(START_CYCLES - 1)) begin
          w_start_n = 1'b0;
          w_cnt_n   = '0;
          w_state_n = S_WAIT;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        // Only a fresh rising edge of done completes; a level left over from
        // the previous job is masked by done_q.
        if (exp_done && !r_done_q) begin
          w_res_n   = {exp_int, exp_frac};
          w_ox_n    = r_x;
          w_to_n    = 1'b0;
          w_valid_n = 1'b1;
          w_state_n = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_res_n   = '0;
          w_ox_n    = r_x;
          w_to_n    = 1'b1;
          w_valid_n = 1'b1;
          w_state_n = S_RESP;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (out_ready) begin
          w_valid_n = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

endmodule

// File: tb/tb_exp_job_sequencer.sv
// Bench for exp_job_sequencer: behavioural evaluator, occupancy model and a
// scoreboard of expected tagged results checked by an independent monitor.
module tb_exp_job_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] MAGIC = 16'hFFFF;   // evaluator never answers this x

  logic        clk, rst, in_valid, in_ready, exp_start, exp_done;
  logic        out_valid, out_ready, out_timeout, busy;
  logic [15:0] in_x, exp_x, exp_frac, out_x;
  logic [1:0]  exp_int;
  logic [17:0] out_result;
  logic [2:0]  q_count;

  exp_job_sequencer #(.DEPTH(DEPTH), .START_CYCLES(2), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_ready(in_ready),
    .exp_start(exp_start), .exp_x(exp_x), .exp_done(exp_done), .exp_int(exp_int),
    .exp_frac(exp_frac), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_result(out_result), .out_timeout(out_timeout), .busy(busy), .q_count(q_count)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [17:0] res;
    logic        to;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int   ev_lat = 10;
  bit   ev_stale = 0;
  bit   rand_ready = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference exponential table for the values of interest; other arguments
  // get an arbitrary but deterministic answer.
  function automatic logic [17:0] eval_fn(input logic [15:0] x);
    case (x)
      16'h0000: return 18'h10000;
      16'h4000: return 18'h148B6;
      16'h8000: return 18'h1A612;
      default:  return {x[1:0], x ^ 16'hA5C3};
    endcase
  endfunction

  // Behavioural evaluator: done is a level that stays high until the next start.
  initial begin : evaluator
    logic [15:0] cap_x;
    int  lat, stale_cnt, low_cnt;
    bit  active, prev_start, rise_chk;
    exp_done = 1'b0; exp_int = '0; exp_frac = '0;
    cap_x = '0; lat = 0; stale_cnt = 0; low_cnt = 0;
    active = 0; prev_start = 0; rise_chk = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        exp_done = 1'b0; exp_int = '0; exp_frac = '0;
        active = 0; prev_start = 0; rise_chk = 0;
      end else begin
        if (rise_chk) begin
          check("valid_after_done", 32'(out_valid), 32'd1);
          rise_chk = 0;
        end
        if (exp_start && !prev_start) begin
          cap_x  = exp_x;
          active = 1;
          if (ev_stale && exp_done) begin
            stale_cnt = 8; low_cnt = 3; lat = 0;
          end else begin
            stale_cnt = 0; low_cnt = 0;
            exp_done = 1'b0;
            lat = (cap_x == MAGIC) ? -1 : ev_lat;
          end
        end else if (active) begin
          check("exp_x_stable", 32'(exp_x), 32'(cap_x));
          if (stale_cnt > 0) begin
            stale_cnt--;
            if (stale_cnt == 0) exp_done = 1'b0;
          end else if (low_cnt > 0 || lat > 0) begin
            if (low_cnt > 0) low_cnt--; else lat--;
            if (low_cnt == 0 && lat == 0) begin
              check("valid_before_done", 32'(out_valid), 32'd0);
              {exp_int, exp_frac} = eval_fn(cap_x);
              exp_done = 1'b1;
              active   = 0;
              rise_chk = 1;
            end
          end
        end
        prev_start = exp_start;
      end
    end
  end

  // Monitor: occupancy model, input scoreboard push, output compare, hold checks.
  initial begin : monitor
    int   pred_cnt;
    bit   have_pred, hold_chk, push, pop;
    exp_t e, h;
    pred_cnt = 0; have_pred = 0; hold_chk = 0; h = '0;
    forever begin
      @(negedge clk);
      if (have_pred) begin
        check("q_count", 32'(q_count), 32'(pred_cnt));
        check("in_ready", 32'(in_ready), 32'(q_count != 3'(DEPTH)));
      end
      if (hold_chk) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_x", 32'(out_x), 32'(h.x));
        check("hold_result", 32'(out_result), 32'(h.res));
        check("hold_timeout", 32'(out_timeout), 32'(h.to));
      end
      if (rst) begin
        sb.delete();
        pred_cnt = 0; have_pred = 1; hold_chk = 0;
      end else begin
        push = in_valid && in_ready;
        pop  = !busy && (q_count != '0);
        pred_cnt = int'(q_count) + int'(push) - int'(pop);
        have_pred = 1;
        if (push) begin
          e.x   = in_x;
          e.to  = (in_x == MAGIC);
          e.res = e.to ? 18'h0 : eval_fn(in_x);
          sb.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_empty: got result for x=0x%0h expected none", out_x);
          end else begin
            e = sb.pop_front();
            check("out_x", 32'(out_x), 32'(e.x));
            check("out_result", 32'(out_result), 32'(e.res));
            check("out_timeout", 32'(out_timeout), 32'(e.to));
          end
        end
        hold_chk = out_valid && !out_ready;
        h.x = out_x; h.res = out_result; h.to = out_timeout;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
      ev_lat    = int'($urandom_range(4, 20));
    end
  endtask

  task automatic push(input logic [15:0] x);
    bit acc;
    int k;
    in_valid = 1'b1; in_x = x; acc = 0; k = 0;
    while (!acc && k < 3000) begin
      acc = in_ready;
      step();
      k++;
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy || q_count != '0) && k < 5000) begin
      step();
      k++;
    end
    check("drain", 32'(k < 5000), 32'd1);
  endtask

  initial begin : stim
    int n, k;
    bit found;
    logic [15:0] x;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_exp_start", 32'(exp_start), 32'd0);
    check("rst_exp_x", 32'(exp_x), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_timeout", 32'(out_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Single job, latency 40, start pulse timing
    ev_lat = 40;
    push(16'h8000);
    check("t0_q_count", 32'(q_count), 32'd1);
    check("t0_exp_start", 32'(exp_start), 32'd0);
    step();
    check("t1_exp_start", 32'(exp_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    step();
    check("t2_exp_start", 32'(exp_start), 32'd1);
    step();
    check("t3_exp_start", 32'(exp_start), 32'd0);
    drain();

    // Back-to-back known arguments
    ev_lat = 6;
    push(16'h0000); push(16'h4000); push(16'h8000);
    drain();

    // Fill the queue while the evaluator stalls
    ev_lat = 30;
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
    check("full_q_count", 32'(q_count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_x = 16'h6666;
    repeat (4) begin
      step();
      check("full_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    found = 0; k = 0;
    while (!found && k < 400) begin
      if (!busy && q_count == 3'd3) found = 1;
      else begin step(); k++; end
    end
    check("pushpop_found", 32'(found), 32'd1);
    if (found) begin
      in_valid = 1'b1; in_x = 16'h7777;
      step();
      in_valid = 1'b0;
      check("pushpop_q_count", 32'(q_count), 32'd3);
      check("pushpop_start", 32'(exp_start), 32'd1);
    end
    drain();

    // done held high across the job boundary
    ev_stale = 1; ev_lat = 8;
    push(16'h0100); push(16'h0200); push(16'h0300);
    drain();
    ev_stale = 0;

    // Evaluator never answers; consumer stalls 10 cycles
    out_ready = 1'b0; ev_lat = 12;
    push(MAGIC); push(16'h1234);
    k = 0;
    while (exp_start && k < 20) begin step(); k++; end
    n = 0;
    while (!out_valid && n < 1100) begin step(); n++; end
    check("timeout_cycles", 32'(n), 32'd1023);
    check("timeout_flag", 32'(out_timeout), 32'd1);
    check("timeout_result", 32'(out_result), 32'd0);
    repeat (10) step();
    out_ready = 1'b1;
    drain();

    // Randomized traffic
    rand_ready = 1;
    for (int j = 0; j < 40; j++) begin
      x = 16'($urandom);
      if (x == MAGIC) x = 16'h0001;
      repeat ($urandom_range(0, 3)) step();
      push(x);
    end
    rand_ready = 0; out_ready = 1'b1;
    drain();

    // Reset mid-WAIT with three entries queued
    ev_lat = 200;
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    repeat (8) step();
    check("pre_rst_q_count", 32'(q_count), 32'd3);
    rst = 1'b1;
    step();
    check("mid_rst_q_count", 32'(q_count), 32'd0);
    check("mid_rst_exp_start", 32'(exp_start), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    ev_lat = 10;
    push(16'h4000);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
